nes_pad_scanner: RTL and testbench
==================================

NES_PAD_SCANNER -- requirements
Module: nes_pad_scanner

Interface
REQ-001 Parameter NUM_PADS, default 2, meaning number of controller ports scanned in parallel (legal range 1..4).
REQ-002 Parameter NUM_BITS, default 8, meaning serial bits read per pad (8 = NES, 16 = SNES).
REQ-003 Parameter CLK_HZ, default 40000000, meaning pixelClock frequency; T12 = CLK_HZ/1000000*12 cycles, T6 = T12/2.
REQ-004 pixelClock  in  1  sole clock; all logic on rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 vSyncStart  in  1  one-cycle frame-start request.
REQ-007 padData  in  NUM_PADS  serial data per pad, active-low button level.
REQ-008 padLatch  out  1  shared latch line to all pads.
REQ-009 padPulse  out  1  shared clock line to all pads.
REQ-010 buttons  out  NUM_PADS*NUM_BITS  committed button state, 1 = pressed; pad p bit k at index p*NUM_BITS+k.
REQ-011 pressed  out  NUM_PADS*NUM_BITS  one-cycle rising-edge flags, same layout.
REQ-012 released  out  NUM_PADS*NUM_BITS  one-cycle falling-edge flags, same layout.
REQ-013 frameValid  out  1  one-cycle pulse when buttons is updated.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, LATCH, READ, COMMIT; a single 16-bit slot counter and a bit index of width ceil(log2(NUM_BITS)) or wider.
REQ-016 IDLE: padLatch=0, padPulse=0; vSyncStart=1 -> LATCH with counter=0.
REQ-017 LATCH: padLatch=1 for exactly T12 cycles (counter 0..T12-1); then -> READ with index=0, counter=0, padLatch=0.
REQ-018 READ slot length is exactly T12 cycles (counter 0..T12-1).
REQ-019 READ: padPulse=1 for counter 0..T6-1 when index>0; padPulse=0 for the whole slot when index=0; padPulse=0 for counter T6..T12-1 always.
REQ-020 READ: at counter==T6, shadow bit [p*NUM_BITS+index] <= ~padData[p] for every p, simultaneously.
REQ-021 READ: at counter==T12-1, if index==NUM_BITS-1 -> COMMIT, else index+1 and counter=0.
REQ-022 COMMIT (one cycle): buttons<=shadow; pressed<=shadow&~buttons; released<=~shadow&buttons; frameValid<=1; -> IDLE.
REQ-023 pressed, released, frameValid are zero in every cycle except the one following COMMIT.
REQ-024 buttons changes only at COMMIT; partial scans are never visible.
REQ-025 Total scan length from the cycle after vSyncStart to frameValid high = T12*(NUM_BITS+1)+1 cycles.
REQ-026 vSyncStart while busy=1 is ignored; the scan in progress completes unchanged.
REQ-027 vSyncStart in the same cycle as COMMIT is ignored; scanning resumes on the next vSyncStart seen in IDLE.
REQ-028 Counter comparisons use full 16-bit width; T12 must be less than 65536, otherwise elaboration fails.

Reset
REQ-029 resetN=0 asynchronously forces IDLE and sets padLatch, padPulse, buttons, pressed, released, frameValid, busy, shadow, counter and index to 0.
REQ-030 Reset asserted mid-scan aborts the scan; after release no COMMIT occurs until a new vSyncStart.
REQ-031 The first scan after reset reports every held button in pressed, because buttons starts at 0.

Verification
REQ-032 Bench runs with CLK_HZ=1000000 (T12=12, T6=6), NUM_PADS=2, NUM_BITS=8, plus one run with NUM_BITS=16.
REQ-033 Basic scan: pad0 model holds A and Right (bits 0, 7), pad1 holds none; pulse vSyncStart -> latch high 12 cycles, 7 pulses of 6 cycles high, frameValid 109 cycles after vSyncStart, buttons=16'h0081, pressed=16'h0081.
REQ-034 Edge detect: next frame pad0 releases A and adds pad1 Start (bit 3) -> buttons=16'h0880, pressed=16'h0800, released=16'h0001, each high for exactly one cycle.
REQ-035 Re-trigger: vSyncStart at cycle 30 of a running scan -> no restart; frameValid still at cycle 109 of the original scan.
REQ-036 Mid-scan reset: resetN low at READ index 4 -> all outputs 0 immediately; after release, no frameValid until a new vSyncStart.
REQ-037 SNES width: NUM_BITS=16 with pad1 bit 11 held -> 15 pulses, frameValid at cycle 205, buttons[27]=1 and all other bits 0.

Source files
------------

// File: rtl/nes_pad_scanner_if.sv
// Pad-side and host-side signal bundle for nes_pad_scanner.
// The master modport is the scanner; the slave modport is the frame consumer and pad model.
interface nes_pad_scanner_if #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8
);
  logic                         vSyncStart;
  logic [NUM_PADS-1:0]          padData;
  logic                         padLatch;
  logic                         padPulse;
  logic [NUM_PADS*NUM_BITS-1:0] buttons;
  logic [NUM_PADS*NUM_BITS-1:0] pressed;
  logic [NUM_PADS*NUM_BITS-1:0] released;
  logic                         frameValid;
  logic                         busy;

  modport master (
    input  vSyncStart, padData,
    output padLatch, padPulse, buttons, pressed, released, frameValid, busy
  );

  modport slave (
    output vSyncStart, padData,
    input  padLatch, padPulse, buttons, pressed, released, frameValid, busy
  );
endinterface

// File: rtl/nes_pad_scanner.sv
// Parallel NES/SNES controller scanner: one latch pulse, NUM_BITS serial slots,
// then an atomic commit of all pads with press/release edge flags.
module nes_pad_scanner #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8,
  parameter int CLK_HZ   = 40000000
) (
  input  logic                pixelClock,
  input  logic                resetN,
  nes_pad_scanner_if.master   bus
);

  localparam int T12_I = CLK_HZ / 1000000 * 12;
  localparam int T6_I  = T12_I / 2;
  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int W     = NUM_PADS * NUM_BITS;

  localparam logic [15:0]      T12_M1   = 16'(T12_I - 1);
  localparam logic [15:0]      T6_C     = 16'(T6_I);
  localparam logic [15:0]      T6_M1    = 16'(T6_I - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

  generate
    if (T12_I >= 65536 || T12_I < 2) begin : g_bad_clk
      $error("nes_pad_scanner: CLK_HZ gives a 12us slot outside 2..65535 cycles");
    end
    if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pads
      $error("nes_pad_scanner: NUM_PADS must be 1..4");
    end
    if (NUM_BITS < 1 || NUM_BITS > 65536) begin : g_bad_bits
      $error("nes_pad_scanner: NUM_BITS out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    READ   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t           state_r;
  logic [15:0]      counter_r;
  logic [IDX_W-1:0] index_r;
  logic [W-1:0]     shadow_r;
  logic             latch_r;
  logic             pulse_r;
  logic [W-1:0]     buttons_r;
  logic [W-1:0]     pressed_r;
  logic [W-1:0]     released_r;
  logic             valid_r;
  logic             busy_r;

  // Scan sequencer; every output is a register updated alongside the state.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state_r    <= IDLE;
      counter_r  <= 16'd0;
      index_r    <= '0;
      shadow_r   <= '0;
      latch_r    <= 1'b0;
      pulse_r    <= 1'b0;
      buttons_r  <= '0;
      pressed_r  <= '0;
      released_r <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      pressed_r  <= '0;
      released_r <= '0;
      valid_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          latch_r <= 1'b0;
          pulse_r <= 1'b0;
          if (bus.vSyncStart) begin
            state_r   <= LATCH;
            counter_r <= 16'd0;
            latch_r   <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        LATCH: begin
          if (counter_r == T12_M1) begin
            state_r   <= READ;
            counter_r <= 16'd0;
            index_r   <= '0;
            latch_r   <= 1'b0;
          end else begin
            counter_r <= counter_r + 16'd1;
          end
        end
        READ: begin
          // Pads have settled half a slot after the pulse edge; sample all pads together.
          if (counter_r == T6_C) begin
            for (int p = 0; p < NUM_PADS; p++) begin
              shadow_r[p*NUM_BITS + int'(index_r)] <= ~bus.padData[p];
            end
          end
          if (counter_r == T12_M1) begin
            counter_r <= 16'd0;
            if (index_r == LAST_IDX) begin
              state_r <= COMMIT;
              pulse_r <= 1'b0;
            end else begin
              index_r <= index_r + IDX_W'(1);
              pulse_r <= 1'b1;
            end
          end else begin
            counter_r <= counter_r + 16'd1;
            if (counter_r == T6_M1) begin
              pulse_r <= 1'b0;
            end
          end
        end
        COMMIT: begin
          buttons_r  <= shadow_r;
          pressed_r  <= shadow_r & ~buttons_r;
          released_r <= ~shadow_r & buttons_r;
          valid_r    <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          latch_r <= 1'b0;
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.padLatch   = latch_r;
  assign bus.padPulse   = pulse_r;
  assign bus.buttons    = buttons_r;
  assign bus.pressed    = pressed_r;
  assign bus.released   = released_r;
  assign bus.frameValid = valid_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Directed bench for nes_pad_scanner: an 8-bit NES instance and a 16-bit SNES instance,
// each driven by a behavioural shift-register pad model.
module tb_nes_pad_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n8  = 1'b0;
  logic rst_n16 = 1'b0;
  logic vs8     = 1'b0;
  logic vs16    = 1'b0;
  logic sel     = 1'b0;

  logic [15:0] held8  = 16'h0000;
  logic [31:0] held16 = 32'h0000_0000;

  int checks = 0;
  int errors = 0;

  nes_pad_scanner_if #(.NUM_PADS(2), .NUM_BITS(8))  bus8 ();
  nes_pad_scanner_if #(.NUM_PADS(2), .NUM_BITS(16)) bus16 ();

  nes_pad_scanner #(.NUM_PADS(2), .NUM_BITS(8), .CLK_HZ(1000000)) u_nes (
    .pixelClock (clk),
    .resetN     (rst_n8),
    .bus        (bus8)
  );

  nes_pad_scanner #(.NUM_PADS(2), .NUM_BITS(16), .CLK_HZ(1000000)) u_snes (
    .pixelClock (clk),
    .resetN     (rst_n16),
    .bus        (bus16)
  );

  assign bus8.vSyncStart  = vs8;
  assign bus16.vSyncStart = vs16;

  // Pad model: latch reloads bit 0, each rising pulse advances to the next bit.
  int   pidx8  = 0;
  int   pidx16 = 0;
  logic pp8    = 1'b0;
  logic pp16   = 1'b0;

  always @(posedge clk) begin
    if (bus8.padLatch) pidx8 <= 0;
    else if (bus8.padPulse && !pp8) pidx8 <= pidx8 + 1;
    pp8 <= bus8.padPulse;
    if (bus16.padLatch) pidx16 <= 0;
    else if (bus16.padPulse && !pp16) pidx16 <= pidx16 + 1;
    pp16 <= bus16.padPulse;
  end

  logic [1:0] pd8;
  logic [1:0] pd16;
  always_comb begin
    pd8  = 2'b00;
    pd16 = 2'b00;
    for (int p = 0; p < 2; p++) begin
      pd8[p]  = (pidx8  < 8)  ? ~held8[p*8 + (pidx8 % 8)]      : 1'b0;
      pd16[p] = (pidx16 < 16) ? ~held16[p*16 + (pidx16 % 16)]  : 1'b0;
    end
  end
  assign bus8.padData  = pd8;
  assign bus16.padData = pd16;

  logic        m_latch, m_pulse, m_fv, m_busy;
  logic [31:0] m_btn, m_prs, m_rel;
  assign m_latch = sel ? bus16.padLatch   : bus8.padLatch;
  assign m_pulse = sel ? bus16.padPulse   : bus8.padPulse;
  assign m_fv    = sel ? bus16.frameValid : bus8.frameValid;
  assign m_busy  = sel ? bus16.busy       : bus8.busy;
  assign m_btn   = sel ? bus16.buttons    : {16'h0000, bus8.buttons};
  assign m_prs   = sel ? bus16.pressed    : {16'h0000, bus8.pressed};
  assign m_rel   = sel ? bus16.released   : {16'h0000, bus8.released};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vs(input logic v);
    if (sel) vs16 = v;
    else     vs8  = v;
  endtask

  // One frame: pulse vSyncStart, watch the line protocol cycle by cycle, check the commit.
  task automatic scan(input string tag, input logic [31:0] held, input logic [31:0] eb,
                      input logic [31:0] ep, input logic [31:0] er, input int retrig,
                      input int exp_pulses, input int exp_fv);
    int cyc, latch_n, pulses, run, bad_len, fv_n, fv_at, spurious, btn_chg;
    logic prev, busy0;
    logic [31:0] btn0, cb, cp, cr;
    if (sel) held16 = held;
    else     held8  = held[15:0];
    @(negedge clk); set_vs(1'b1);
    @(negedge clk); set_vs(1'b0);
    cyc = 0; latch_n = 0; pulses = 0; run = 0; bad_len = 0; fv_n = 0; fv_at = -1;
    spurious = 0; btn_chg = 0; prev = 1'b0; busy0 = m_busy; btn0 = m_btn;
    cb = 32'h0; cp = 32'h0; cr = 32'h0;
    while (cyc <= exp_fv + 4) begin
      if (m_latch) latch_n++;
      if (m_pulse) begin
        if (!prev) pulses++;
        run++;
      end else begin
        if (prev && run != 6) bad_len++;
        run = 0;
      end
      prev = m_pulse;
      if (m_fv) begin
        fv_n++; fv_at = cyc; cb = m_btn; cp = m_prs; cr = m_rel;
      end else begin
        if ((m_prs | m_rel) != 32'h0) spurious++;
        if (fv_n == 0 && m_btn != btn0) btn_chg++;
      end
      set_vs(cyc == retrig);
      @(posedge clk); #1;
      cyc++;
    end
    set_vs(1'b0);
    chk({tag, " busy_start"},  {31'h0, busy0},  32'h1);
    chk({tag, " latch_len"},   latch_n,         32'd12);
    chk({tag, " pulse_count"}, pulses,          exp_pulses);
    chk({tag, " pulse_width"}, bad_len,         32'd0);
    chk({tag, " fv_count"},    fv_n,            32'd1);
    chk({tag, " fv_cycle"},    fv_at,           exp_fv);
    chk({tag, " buttons"},     cb,              eb);
    chk({tag, " pressed"},     cp,              ep);
    chk({tag, " released"},    cr,              er);
    chk({tag, " edge_oneshot"}, spurious,       32'd0);
    chk({tag, " btn_atomic"},  btn_chg,         32'd0);
    chk({tag, " busy_end"},    {31'h0, m_busy}, 32'h0);
  endtask

  typedef struct {
    logic [15:0] held;
    logic [15:0] eb;
    logic [15:0] ep;
    logic [15:0] er;
    int          retrig;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fv_seen, busy_seen;
    vecs[0] = '{16'h0081, 16'h0081, 16'h0081, 16'h0000, -1};
    vecs[1] = '{16'h0880, 16'h0880, 16'h0800, 16'h0001, -1};
    vecs[2] = '{16'h0880, 16'h0880, 16'h0000, 16'h0000, 30};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0880, -1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, -1};
    vecs[5] = '{16'hA55A, 16'hA55A, 16'h0000, 16'h5AA5, -1};

    repeat (3) @(negedge clk);
    chk("rst8 buttons", {16'h0, bus8.buttons}, 32'h0);
    chk("rst8 lines",   {30'h0, bus8.padLatch, bus8.padPulse}, 32'h0);
    chk("rst8 busy_fv", {30'h0, bus8.busy, bus8.frameValid}, 32'h0);
    chk("rst16 buttons", bus16.buttons, 32'h0);
    rst_n8 = 1'b1; rst_n16 = 1'b1;
    repeat (2) @(negedge clk);

    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      scan($sformatf("nes_v%0d", i), {16'h0, vecs[i].held}, {16'h0, vecs[i].eb},
           {16'h0, vecs[i].ep}, {16'h0, vecs[i].er}, vecs[i].retrig, 7, 109);
    end

    // Abort in READ slot 4 while a pulse is high; everything clears at once.
    held8 = 16'h0081;
    @(negedge clk); vs8 = 1'b1;
    @(negedge clk); vs8 = 1'b0;
    repeat (63) @(posedge clk);
    #1;
    chk("midrst pulse_before", {31'h0, bus8.padPulse}, 32'h1);
    rst_n8 = 1'b0;
    #1;
    chk("midrst buttons",  {16'h0, bus8.buttons}, 32'h0);
    chk("midrst lines",    {30'h0, bus8.padLatch, bus8.padPulse}, 32'h0);
    chk("midrst edges",    {bus8.pressed, bus8.released}, 32'h0);
    chk("midrst busy_fv",  {30'h0, bus8.busy, bus8.frameValid}, 32'h0);
    @(negedge clk); rst_n8 = 1'b1;
    fv_seen = 0; busy_seen = 0;
    repeat (250) begin
      @(posedge clk); #1;
      if (bus8.frameValid) fv_seen++;
      if (bus8.busy) busy_seen++;
    end
    chk("midrst no_fv",   fv_seen,   32'd0);
    chk("midrst no_busy", busy_seen, 32'd0);

    scan("nes_after_rst", 32'h0000_0081, 32'h0000_0081, 32'h0000_0081, 32'h0, -1, 7, 109);

    sel = 1'b1;
    scan("snes_hold", 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0, -1, 15, 205);
    scan("snes_rel",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0800_0000, -1, 15, 205);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
